// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM state type shared by alu_mdu
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_SLL   = 4'b0010;
   localparam logic [3:0] OP_SLT   = 4'b0011;
   localparam logic [3:0] OP_SLTU  = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_OR    = 4'b1000;
   localparam logic [3:0] OP_AND   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIV   = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_REM   = 4'b1110;
   localparam logic [3:0] OP_REMU  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Opcodes 1010..1111 belong to the iterative multiply/divide unit.
   function automatic logic is_mdu_op(input logic [3:0] op);
      return op[3] & (op[2] | op[1]);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// Ports: clk, rst_n (async active-low); start loads a, b, op (low 3 opcode bits);
//        done pulses one cycle with result valid WIDTH cycles after start.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   logic                 r_busy;
   logic [CW-1:0]        r_cnt;
   logic [2:0]           r_op;
   logic [2*WIDTH-1:0]   r_prod;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_div;
   logic                 r_dz;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_done;
   logic [WIDTH-1:0]     r_result;

   logic                 w_sgn;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_prod_nxt;
   logic [WIDTH:0]       w_shift;
   logic [WIDTH-1:0]     w_diff;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_nxt;
   logic [WIDTH-1:0]     w_quo_nxt;
   logic [WIDTH-1:0]     w_final;

   // op: [2]=divide, [1]=remainder (divide only), [0]=unsigned / high half
   assign w_sgn   = op[2] & ~op[0];
   assign w_abs_a = (w_sgn && a[WIDTH-1]) ? -a : a;
   assign w_abs_b = (w_sgn && b[WIDTH-1]) ? -b : b;

   // Multiplier: low half of r_prod holds the remaining multiplier bits.
   assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
   assign w_prod_nxt = r_prod[0] ? {w_sum, r_prod[WIDTH-1:1]}
                                 : {1'b0, r_prod[2*WIDTH-1:1]};

   // Divider: dividend bits shift out of r_quo into the partial remainder.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_div});
   assign w_diff    = w_shift[WIDTH-1:0] - r_div;
   assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

   // Final value formed from the last iteration's next-state values.
   always_comb begin
      w_final = '0;
      if (!r_op[2]) begin
         w_final = r_op[0] ? w_prod_nxt[2*WIDTH-1:WIDTH] : w_prod_nxt[WIDTH-1:0];
      end else if (!r_op[1]) begin
         if (r_dz)
            w_final = '1;
         else
            w_final = r_neg_q ? -w_quo_nxt : w_quo_nxt;
      end else begin
         // Divide by zero leaves the dividend in the remainder naturally.
         w_final = r_neg_r ? -w_rem_nxt : w_rem_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_dz     <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_op    <= op;
            r_prod  <= {{WIDTH{1'b0}}, a};
            r_mcand <= b;
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_div   <= w_abs_b;
            r_dz    <= (b == '0);
            r_neg_q <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= w_sgn & a[WIDTH-1];
         end else if (r_busy) begin
            r_prod <= w_prod_nxt;
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1)) begin
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_result <= w_final;
            end
         end
      end
   end

   assign done   = r_done;
   assign result = r_result;

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - single-cycle ALU with optional iterative multiply/divide behind valid/ready
// Build option: define ALU_MDU_M_EN to include the multiply/divide datapath (mdu_iter).
// Ports: clk, rst_n (async active-low); request in_valid/in_ready/in_a/in_b/alu_control;
//        response out_valid/out_ready/result/zero/err.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   state_t           r_state;
   logic             r_rst_done;
   logic             r_out_valid;
   logic             r_err;
   logic [WIDTH-1:0] r_result;

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_mdu_done;
   logic [WIDTH-1:0] w_mdu_result;

   // r_rst_done keeps in_ready low until the first edge after reset release.
   assign in_ready = r_rst_done && (r_state == ST_IDLE);
   assign w_accept = in_valid && in_ready;
   assign w_shamt  = in_b[SHW-1:0];

   always_comb begin
      w_alu_result = '0;
      case (alu_control)
         OP_ADD:  w_alu_result = in_a + in_b;
         OP_SUB:  w_alu_result = in_a - in_b;
         OP_SLL:  w_alu_result = in_a << w_shamt;
         OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         OP_XOR:  w_alu_result = in_a ^ in_b;
         OP_SRL:  w_alu_result = in_a >> w_shamt;
         OP_SRA:  w_alu_result = $signed(in_a) >>> w_shamt;
         OP_OR:   w_alu_result = in_a | in_b;
         OP_AND:  w_alu_result = in_a & in_b;
         default: w_alu_result = '0;
      endcase
   end

`ifdef ALU_MDU_M_EN
   logic w_mdu_start;

   // Operands go straight into mdu_iter on the accept edge, so the unit
   // starts counting immediately and later input changes cannot leak in.
   assign w_mdu_start = w_accept && is_mdu_op(alu_control);

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (w_mdu_start),
      .op     (alu_control[2:0]),
      .a      (in_a),
      .b      (in_b),
      .done   (w_mdu_done),
      .result (w_mdu_result)
   );
`else
   assign w_mdu_done   = 1'b0;
   assign w_mdu_result = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rst_done  <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_err       <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (is_mdu_op(alu_control)) begin
`ifdef ALU_MDU_M_EN
                     r_state <= ST_BUSY;
`else
                     r_state     <= ST_DONE;
                     r_result    <= '0;
                     r_err       <= 1'b1;
                     r_out_valid <= 1'b1;
`endif
                  end else begin
                     r_state     <= ST_DONE;
                     r_result    <= w_alu_result;
                     r_err       <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (w_mdu_done) begin
                  r_state     <= ST_DONE;
                  r_result    <= w_mdu_result;
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = (r_result == '0);
   assign err       = r_err;

endmodule
